// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 keycode tracker.
package ps2_pkg;

    localparam logic [7:0] PS2_BREAK  = 8'hF0;
    localparam logic [7:0] PS2_EXT    = 8'hE0;
    localparam logic [7:0] KEY_NONE   = 8'h00;
    localparam logic [7:0] PS2_ERR    = 8'hFF;

    localparam int FRAME_BITS = 11;
    localparam int BITCNT_W   = $clog2(FRAME_BITS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        CHECK = 2'd2
    } rx_state_e;

    // Odd parity over data plus parity bit, and stop bit must be high.
    function automatic logic frame_ok(input logic [9:0] bits);
        return (^bits[8:0]) & bits[9];
    endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 frame receiver: synchronises the keyboard lines, deframes 11-bit words
// and flags each completed frame as good (rx_valid) or bad (rx_err) for one cycle.
module ps2_rx_frame
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYC = 100000,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       rx_err
);

    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [SYNC_STAGES-1:0] r_clk_sync;
    logic [SYNC_STAGES-1:0] r_data_sync;
    logic                   r_clk_prev;
    rx_state_e              r_state;
    rx_state_e              w_state_n;
    logic [BITCNT_W-1:0]    r_bitcnt;
    logic [9:0]             r_shift;
    logic [TW-1:0]          r_to;
    logic                   w_clk_s;
    logic                   w_data_s;
    logic                   w_fall;
    logic                   w_ok;

    assign w_clk_s  = r_clk_sync[SYNC_STAGES-1];
    assign w_data_s = r_data_sync[SYNC_STAGES-1];
    assign w_fall   = r_clk_prev & ~w_clk_s;
    assign w_ok     = frame_ok(r_shift);
    assign rx_byte  = r_shift[7:0];

    // Lines idle high, so the synchronisers reset to 1 to avoid a false edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_clk_sync  <= '1;
            r_data_sync <= '1;
            r_clk_prev  <= 1'b1;
        end else begin
            r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0], ps2_clk};
            r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], ps2_data};
            r_clk_prev  <= w_clk_s;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_state_n;
    end

    always_comb begin
        w_state_n = r_state;
        case (r_state)
            IDLE:  if (w_fall && !w_data_s) w_state_n = RECV;
            RECV: begin
                if (w_fall) begin
                    if (r_bitcnt == BITCNT_W'(FRAME_BITS-1)) w_state_n = CHECK;
                end else if (r_to == TW'(TIMEOUT_CYC-1)) begin
                    w_state_n = IDLE;
                end
            end
            CHECK: w_state_n = IDLE;
            default: w_state_n = IDLE;
        endcase
    end

    always_comb begin
        rx_valid = 1'b0;
        rx_err   = 1'b0;
        if (r_state == CHECK) begin
            rx_valid = w_ok;
            rx_err   = ~w_ok;
        end
    end

    // Bits shift in from the top, so after the stop bit r_shift = {stop, parity, data}.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_bitcnt <= '0;
            r_shift  <= '0;
            r_to     <= '0;
        end else begin
            if (w_fall)              r_to <= '0;
            else if (r_state == RECV) r_to <= r_to + TW'(1);
            else                     r_to <= '0;

            if (r_state == IDLE && w_fall && !w_data_s) begin
                r_bitcnt <= BITCNT_W'(1);
            end else if (r_state == RECV && w_fall) begin
                r_bitcnt <= r_bitcnt + BITCNT_W'(1);
                r_shift  <= {w_data_s, r_shift[9:1]};
            end
        end
    end

endmodule

// File: rtl/ps2_keycode_tracker.sv
// Decodes PS/2 make/break/prefix bytes and tracks up to two held keys as a
// registered {slot1, slot0} keycode word for the PIO.
module ps2_keycode_tracker
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYC = 100000,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [15:0] keycode,
    output logic        frame_valid,
    output logic        parity_err
);

    logic [7:0] w_rx_byte;
    logic       w_rx_valid;
    logic       w_rx_err;
    logic [7:0] r_slot0, r_slot1;
    logic [7:0] w_slot0_n, w_slot1_n;
    logic       r_ext, r_brk;
    logic       w_ext_n, w_brk_n;
    logic       r_frame_valid, r_parity_err;

    ps2_rx_frame #(
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_rx (
        .clk      (clk),
        .reset_n  (reset_n),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .rx_byte  (w_rx_byte),
        .rx_valid (w_rx_valid),
        .rx_err   (w_rx_err)
    );

    // Extended keys are tracked by their low byte alone; ext only marks the prefix.
    always_comb begin
        w_slot0_n = r_slot0;
        w_slot1_n = r_slot1;
        w_ext_n   = r_ext;
        w_brk_n   = r_brk;
        if (w_rx_valid) begin
            case (w_rx_byte)
                PS2_EXT:   w_ext_n = 1'b1;
                PS2_BREAK: w_brk_n = 1'b1;
                KEY_NONE, PS2_ERR: begin
                    w_ext_n = 1'b0;
                    w_brk_n = 1'b0;
                end
                default: begin
                    w_ext_n = 1'b0;
                    w_brk_n = 1'b0;
                    if (r_brk) begin
                        if (r_slot0 == w_rx_byte) begin
                            w_slot0_n = r_slot1;
                            w_slot1_n = KEY_NONE;
                        end else if (r_slot1 == w_rx_byte) begin
                            w_slot1_n = KEY_NONE;
                        end
                    end else if (r_slot0 != w_rx_byte && r_slot1 != w_rx_byte) begin
                        if (r_slot0 == KEY_NONE)      w_slot0_n = w_rx_byte;
                        else if (r_slot1 == KEY_NONE) w_slot1_n = w_rx_byte;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_slot0       <= KEY_NONE;
            r_slot1       <= KEY_NONE;
            r_ext         <= 1'b0;
            r_brk         <= 1'b0;
            r_frame_valid <= 1'b0;
            r_parity_err  <= 1'b0;
        end else begin
            r_slot0       <= w_slot0_n;
            r_slot1       <= w_slot1_n;
            r_ext         <= w_ext_n;
            r_brk         <= w_brk_n;
            r_frame_valid <= w_rx_valid;
            r_parity_err  <= w_rx_err;
        end
    end

    assign keycode     = {r_slot1, r_slot0};
    assign frame_valid = r_frame_valid;
    assign parity_err  = r_parity_err;

endmodule

// File: tb/tb_ps2_keycode_tracker.sv
// Directed bench for ps2_keycode_tracker: keyboard frames bit-banged on ps2_clk/ps2_data.
module tb_ps2_keycode_tracker;

    localparam int TO = 200;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic [15:0] keycode;
    logic        frame_valid;
    logic        parity_err;

    int n_cmp = 0;
    int n_bad = 0;
    int fv_cnt = 0;
    int pe_cnt = 0;
    int both_cnt = 0;

    always #5 clk = ~clk;

    ps2_keycode_tracker #(.TIMEOUT_CYC(TO), .SYNC_STAGES(2)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .keycode     (keycode),
        .frame_valid (frame_valid),
        .parity_err  (parity_err)
    );

    always @(negedge clk) begin
        if (frame_valid) fv_cnt++;
        if (parity_err) pe_cnt++;
        if (frame_valid && parity_err) both_cnt++;
    end

    function automatic logic [10:0] mkframe(input logic [7:0] b, input logic bad_par, input logic stop_v);
        return {stop_v, (~^b) ^ bad_par, b, 1'b0};
    endfunction

    task automatic send_bit(input logic b);
        ps2_data = b;
        repeat (4) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (4) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_raw(input logic [10:0] f, input int lo, input int hi);
        for (int i = lo; i <= hi; i++) send_bit(f[i]);
        ps2_data = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic key(input logic [7:0] b);
        send_raw(mkframe(b, 1'b0, 1'b1), 0, 10);
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        n_cmp++; if (keycode !== 16'h0000) begin n_bad++; $display("FAIL reset_keycode: got %h want 0000", keycode); end
        n_cmp++; if (frame_valid !== 1'b0) begin n_bad++; $display("FAIL reset_fv: got %b want 0", frame_valid); end
        n_cmp++; if (parity_err !== 1'b0) begin n_bad++; $display("FAIL reset_pe: got %b want 0", parity_err); end
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if (keycode !== 16'h0000) begin n_bad++; $display("FAIL post_reset_keycode: got %h want 0000", keycode); end
    endtask

    task automatic test_latency;
        logic [10:0] f;
        int fv0;
        f = mkframe(8'h1D, 1'b0, 1'b1);
        fv0 = fv_cnt;
        for (int i = 0; i < 10; i++) send_bit(f[i]);
        ps2_data = 1'b1;
        repeat (4) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (frame_valid !== 1'b0 || keycode !== 16'h0000) begin n_bad++; $display("FAIL latency_early: fv=%b kc=%h want fv=0 kc=0000", frame_valid, keycode); end
        @(posedge clk);
        #1;
        n_cmp++; if (frame_valid !== 1'b1) begin n_bad++; $display("FAIL latency_fv: got %b want 1", frame_valid); end
        n_cmp++; if (keycode !== 16'h001D) begin n_bad++; $display("FAIL latency_kc: got %h want 001D", keycode); end
        @(posedge clk);
        #1;
        n_cmp++; if (frame_valid !== 1'b0) begin n_bad++; $display("FAIL latency_pulse_width: fv=%b want 0", frame_valid); end
        repeat (3) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (8) @(negedge clk);
        n_cmp++; if (fv_cnt - fv0 !== 1) begin n_bad++; $display("FAIL latency_count: got %0d pulses want 1", fv_cnt - fv0); end
    endtask

    task automatic test_release;
        key(8'h1C);
        n_cmp++; if (keycode !== 16'h1C1D) begin n_bad++; $display("FAIL second_press: got %h want 1C1D", keycode); end
        key(8'hF0);
        n_cmp++; if (keycode !== 16'h1C1D) begin n_bad++; $display("FAIL break_prefix_only: got %h want 1C1D", keycode); end
        key(8'h1D);
        n_cmp++; if (keycode !== 16'h001C) begin n_bad++; $display("FAIL release_compact: got %h want 001C", keycode); end
    endtask

    task automatic test_repeat_rollover;
        int fv0;
        key(8'h1D);
        n_cmp++; if (keycode !== 16'h1D1C) begin n_bad++; $display("FAIL fill_slot1: got %h want 1D1C", keycode); end
        fv0 = fv_cnt;
        key(8'h23);
        key(8'h1D);
        n_cmp++; if (keycode !== 16'h1D1C) begin n_bad++; $display("FAIL rollover_repeat: got %h want 1D1C", keycode); end
        n_cmp++; if (fv_cnt - fv0 !== 2) begin n_bad++; $display("FAIL rollover_fv_count: got %0d want 2", fv_cnt - fv0); end
    endtask

    task automatic test_errors;
        int fv0, pe0;
        fv0 = fv_cnt;
        pe0 = pe_cnt;
        send_raw(mkframe(8'h1D, 1'b1, 1'b1), 0, 10);
        send_raw(mkframe(8'h1D, 1'b0, 1'b0), 0, 10);
        n_cmp++; if (pe_cnt - pe0 !== 2) begin n_bad++; $display("FAIL err_pe_count: got %0d want 2", pe_cnt - pe0); end
        n_cmp++; if (fv_cnt - fv0 !== 0) begin n_bad++; $display("FAIL err_fv_count: got %0d want 0", fv_cnt - fv0); end
        n_cmp++; if (keycode !== 16'h1D1C) begin n_bad++; $display("FAIL err_keycode: got %h want 1D1C", keycode); end
        key(8'hF0); key(8'h1D);
        n_cmp++; if (keycode !== 16'h001C) begin n_bad++; $display("FAIL release_slot1: got %h want 001C", keycode); end
        key(8'hF0); key(8'h1C);
        n_cmp++; if (keycode !== 16'h0000) begin n_bad++; $display("FAIL release_last: got %h want 0000", keycode); end
    endtask

    task automatic test_timeout;
        int fv0, pe0;
        fv0 = fv_cnt;
        pe0 = pe_cnt;
        send_raw(mkframe(8'h1B, 1'b0, 1'b1), 0, 4);
        repeat (TO + 10) @(negedge clk);
        n_cmp++; if (fv_cnt - fv0 !== 0 || pe_cnt - pe0 !== 0) begin n_bad++; $display("FAIL timeout_pulses: fv=%0d pe=%0d want 0/0", fv_cnt - fv0, pe_cnt - pe0); end
        key(8'h1B);
        n_cmp++; if (keycode !== 16'h001B) begin n_bad++; $display("FAIL after_timeout: got %h want 001B", keycode); end
        key(8'hE0); key(8'h74);
        n_cmp++; if (keycode !== 16'h741B) begin n_bad++; $display("FAIL ext_press: got %h want 741B", keycode); end
        key(8'hE0); key(8'hF0); key(8'h74);
        n_cmp++; if (keycode !== 16'h001B) begin n_bad++; $display("FAIL ext_release: got %h want 001B", keycode); end
        key(8'hF0); key(8'hFF); key(8'h1B);
        n_cmp++; if (keycode !== 16'h001B) begin n_bad++; $display("FAIL err_code_clears_brk: got %h want 001B", keycode); end
    endtask

    task automatic test_reset_midframe;
        logic [10:0] f;
        int fv0, pe0;
        key(8'hF0); key(8'h1B); key(8'h1D); key(8'h1C);
        n_cmp++; if (keycode !== 16'h1C1D) begin n_bad++; $display("FAIL pre_reset_keycode: got %h want 1C1D", keycode); end
        f = mkframe(8'h5A, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) send_bit(f[i]);
        reset_n = 1'b0;
        #1;
        n_cmp++; if (keycode !== 16'h0000) begin n_bad++; $display("FAIL async_reset: got %h want 0000", keycode); end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        fv0 = fv_cnt;
        pe0 = pe_cnt;
        send_raw(f, 4, 10);
        repeat (TO + 10) @(negedge clk);
        n_cmp++; if (fv_cnt - fv0 !== 0 || pe_cnt - pe0 !== 0) begin n_bad++; $display("FAIL tail_discard: fv=%0d pe=%0d want 0/0", fv_cnt - fv0, pe_cnt - pe0); end
        key(8'h29);
        n_cmp++; if (keycode !== 16'h0029) begin n_bad++; $display("FAIL post_reset_frame: got %h want 0029", keycode); end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_release();
        test_repeat_rollover();
        test_errors();
        test_timeout();
        test_reset_midframe();
        n_cmp++; if (both_cnt !== 0) begin n_bad++; $display("FAIL exclusive_pulses: got %0d overlaps want 0", both_cnt); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
